irq_controller: RTL and testbench
=================================

# irq_controller

Eight-input interrupt controller between the external `interrupts[7:0]` pins and the MIPS core's exception logic. It synchronizes, edge-detects or level-samples, masks and prioritizes the lines, and presents one request at a time to the core through a request/acknowledge handshake. New requests are held off while a handler is in service, so activity on the pins during a handler does not disturb that handler. Software configures the block through a small register port on the memory bus.

## Interface
- `NIRQ`, 8: number of interrupt lines; `irqid` width is $clog2(NIRQ).
- `SYNC_STAGES`, 2: synchronizer flops per line (minimum 2).

- `ph1`  in  1  single clock; all state updates on rising `ph1`.
- `reset`  in  1  synchronous, active-high reset.
- `interrupts`  in  NIRQ  asynchronous interrupt pins.
- `ack`  in  1  one-cycle pulse from the core: exception taken for `irqid`.
- `eret`  in  1  one-cycle pulse from the core: handler exited.
- `we`  in  1  register write strobe.
- `adr`  in  2  register select: 0 MASK, 1 EDGE, 2 PENDING, 3 STATUS.
- `wdata`  in  NIRQ  write data.
- `rdata`  out  NIRQ  read data, combinational from `adr`.
- `irq`  out  1  interrupt request to the core.
- `irqid`  out  3  index of the requested line; stable while `irq`=1.
- `busy`  out  1  handler in service.

## Operation
- **Registers**
  - MASK: R/W. Reset value 0x00. A 1 enables the line.
  - EDGE: R/W. Reset value 0xFF. A 1 selects rising-edge mode; a 0 selects level mode.
  - PENDING: R; write-1-to-clear, edge-mode bits only. Reset value 0x00.
  - STATUS: R = {busy, irq, 3'b0, irqid}. Writes are ignored.
- **Pending update per line**
  - Edge mode: set when the synchronized value is 1 and its previous value was 0. Cleared by W1C or by `ack` for the requested line. A set in the same cycle as a clear wins.
  - Level mode: the bit mirrors the synchronized input. W1C and `ack` have no effect.
- **Priority:** among pending&MASK, the lowest index wins (line 0 highest).
- **FSM**
  - IDLE: if pending&MASK≠0, latch `irqid` and go to REQ. `ack` and `eret` are ignored.
  - REQ: `irq`=1 and `irqid` is frozen.
    - On `ack`: clear the edge-mode pending bit and go to SERVICE.
    - Without `ack`: if the latched line's pending&MASK bit reads 0, withdraw to IDLE. `ack` beats withdrawal in the same cycle.
    - A higher-priority arrival does not preempt.
  - SERVICE: `busy`=1 and `irq`=0. Pending bits keep accumulating. On `eret`, go to IDLE. `ack` is ignored.
- **Outputs:** `irq` = (state==REQ) and `busy` = (state==SERVICE), both registered state decodes.
- **Reset, including mid-operation:** on the next edge, synchronizers, pending, MASK and EDGE take their reset values, state goes to IDLE, and `irq`=0, `irqid`=0, `busy`=0.
- A MASK or EDGE write takes effect on the cycle after the write edge.
- An EDGE change from 1 to 0 turns the bit into a level mirror immediately.

## Timing
- The minimum input pulse is 1 `ph1` cycle. Shorter pulses may be lost.
- Pending is set SYNC_STAGES+1 edges after the first edge that samples the pin high.
- `irq` rises 1 edge after pending&MASK becomes nonzero in IDLE: SYNC_STAGES+2 edges pin-to-`irq`, which is 4 by default.
- `ack` seen at edge n: `irq`=0 and `busy`=1 after edge n, and the pending bit is cleared at edge n.
- `eret` at edge n: IDLE after edge n. If a request is still pending, `irq`=1 after edge n+1.
- Withdrawal: `irq` falls 1 edge after the latched line's pending&MASK bit reads 0.
- `rdata` is valid in the same cycle as `adr`. PENDING reflects state as of the last edge.

## Test plan
- **Reset:** assert `reset` for 3 cycles, then read all registers -> `irq`=0, `busy`=0, `irqid`=0, MASK=0x00, EDGE=0xFF, PENDING=0x00.
- **Basic handshake:** write MASK=0x03, pulse `interrupts[1]` for 5 cycles -> `irq`=1 with `irqid`=1 exactly 4 edges after the first sampling edge. Pulse `ack` -> next cycle `irq`=0, `busy`=1, PENDING=0x00.
- **No disturbance during service:** while in SERVICE, pulse `interrupts[1]` -> `irq` stays 0 and PENDING=0x02. Pulse `eret` -> `irq`=1, `irqid`=1 two edges later. W1C 0x02 in REQ instead -> `irq` withdrawn.
- **Priority:** MASK=0xFF, pulse `interrupts[0]` and `interrupts[1]` in the same cycle -> `irqid`=0. Run ack/eret -> `irqid`=1 next, with no preemption in REQ when line 0 arrives after line 1.
- **Level mode and masking:** EDGE=0xFE, MASK=0x01, hold `interrupts[0]` high -> `irq`=1. `ack` then `eret` while still high -> `irq` re-asserts. Drop the pin while in REQ -> `irq`=0 within SYNC_STAGES+1 edges. Pulse `interrupts[2]` -> PENDING bit 2 set but `irq` never asserts.
- **Reset mid-operation and simultaneous events:** assert `reset` during SERVICE -> all reset values next edge, and a following `eret` has no effect. A W1C of a line in the same cycle as its new edge -> pending stays 1.

Source files
------------

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
//  Module      : irq_controller
//  Description : Eight-line interrupt controller for the MIPS core. Pins are
//                synchronized, edge-detected or level-sampled, masked and
//                prioritized (line 0 highest). One request at a time is
//                offered to the core through an irq/ack handshake. New
//                requests are held off until eret ends the handler.
//  Ports       : ph1        - clock, all state updates on rising edge
//                reset      - synchronous active-high reset
//                interrupts - asynchronous interrupt pins
//                ack        - core took the exception for irqid
//                eret       - core left the handler
//                we/adr/wdata/rdata - register port
//                               adr 0 MASK, 1 EDGE, 2 PENDING (W1C), 3 STATUS
//                irq/irqid  - request to the core and its line index
//                busy       - handler in service
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_controller #(
  parameter int NIRQ        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    ph1,
  input  logic                    reset,
  input  logic [NIRQ-1:0]         interrupts,
  input  logic                    ack,
  input  logic                    eret,
  input  logic                    we,
  input  logic [1:0]              adr,
  input  logic [NIRQ-1:0]         wdata,
  output logic [NIRQ-1:0]         rdata,
  output logic                    irq,
  output logic [$clog2(NIRQ)-1:0] irqid,
  output logic                    busy
);

  localparam int IDW = $clog2(NIRQ);

  localparam logic [1:0] c_ADR_MASK    = 2'd0;
  localparam logic [1:0] c_ADR_EDGE    = 2'd1;
  localparam logic [1:0] c_ADR_PENDING = 2'd2;
  localparam logic [1:0] c_ADR_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  logic [NIRQ-1:0] r_sync [SYNC_STAGES];
  logic [NIRQ-1:0] r_prev;
  logic [NIRQ-1:0] r_mask;
  logic [NIRQ-1:0] r_edge;
  logic [NIRQ-1:0] r_pend;
  state_t          r_state;
  logic [IDW-1:0]  r_irqid;

  logic [NIRQ-1:0] w_sync;
  logic [NIRQ-1:0] w_rise;
  logic [NIRQ-1:0] w_clr;
  logic [NIRQ-1:0] w_pend_nxt;
  logic [NIRQ-1:0] w_pending;
  logic [NIRQ-1:0] w_active;
  logic [IDW-1:0]  w_winner;
  logic            w_w1c;
  logic            w_ack_take;
  state_t          w_state_nxt;
  logic [IDW-1:0]  w_irqid_nxt;
  logic [NIRQ-1:0] w_status;

  // --------------------------------------------------------------------------
  // Input synchronizer chain and previous-value register for edge detection
  // --------------------------------------------------------------------------
  always_ff @(posedge ph1) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
      r_prev <= '0;
    end else begin
      r_sync[0] <= interrupts;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
      r_prev <= w_sync;
    end
  end

  assign w_sync     = r_sync[SYNC_STAGES-1];
  assign w_w1c      = we && (adr == c_ADR_PENDING);
  assign w_ack_take = (r_state == S_REQ) && ack;

  // --------------------------------------------------------------------------
  // Per-line pending logic. Edge-mode bits live in r_pend; level-mode bits
  // are a direct mirror of the synchronized pin, so an EDGE 1->0 change
  // shows the live pin immediately. r_pend is held at 0 for level lines.
  // A new rising edge overrides a W1C or ack clear in the same cycle.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NIRQ; i++) begin : g_line
    assign w_rise[i]     = w_sync[i] & ~r_prev[i];
    assign w_clr[i]      = (w_w1c & wdata[i]) |
                           (w_ack_take & (r_irqid == IDW'(i)));
    assign w_pend_nxt[i] = r_edge[i] & (w_rise[i] | (r_pend[i] & ~w_clr[i]));
    assign w_pending[i]  = r_edge[i] ? r_pend[i] : w_sync[i];
  end

  assign w_active = w_pending & r_mask;

  // Lowest index wins: scan from the top so the last hit is the smallest.
  always_comb begin
    w_winner = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_winner = IDW'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Configuration and pending registers
  // --------------------------------------------------------------------------
  always_ff @(posedge ph1) begin
    if (reset) begin
      r_mask <= '0;
      r_edge <= '1;
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (we && (adr == c_ADR_MASK)) begin
        r_mask <= wdata;
      end
      if (we && (adr == c_ADR_EDGE)) begin
        r_edge <= wdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Request FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge ph1) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_irqid <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_irqid <= w_irqid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_irqid_nxt = r_irqid;
    case (r_state)
      S_IDLE: begin
        if (|w_active) begin
          w_state_nxt = S_REQ;
          w_irqid_nxt = w_winner;
        end
      end
      S_REQ: begin
        // ack takes precedence over withdrawal; no preemption while waiting.
        if (ack) begin
          w_state_nxt = S_SERVICE;
        end else if (!w_active[r_irqid]) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (eret) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign irq   = (r_state == S_REQ);
  assign busy  = (r_state == S_SERVICE);
  assign irqid = r_irqid;

  // --------------------------------------------------------------------------
  // Register read mux
  // --------------------------------------------------------------------------
  always_comb begin
    w_status           = '0;
    w_status[NIRQ-1]   = busy;
    w_status[NIRQ-2]   = irq;
    w_status[IDW-1:0]  = r_irqid;
  end

  always_comb begin
    rdata = '0;
    case (adr)
      c_ADR_MASK:    rdata = r_mask;
      c_ADR_EDGE:    rdata = r_edge;
      c_ADR_PENDING: rdata = w_pending;
      c_ADR_STATUS:  rdata = w_status;
      default:       rdata = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_controller
//  Description : Self-checking bench for irq_controller: register vector
//                table, directed handshake/priority/level/reset sequences,
//                and randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

  localparam int SYNC = 2;

  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_SERV = 2;

  logic       ph1;
  logic       reset;
  logic [7:0] interrupts;
  logic       ack;
  logic       eret;
  logic       we;
  logic [1:0] adr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       irq;
  logic [2:0] irqid;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  irq_controller #(
    .NIRQ        (8),
    .SYNC_STAGES (SYNC)
  ) dut (
    .ph1        (ph1),
    .reset      (reset),
    .interrupts (interrupts),
    .ack        (ack),
    .eret       (eret),
    .we         (we),
    .adr        (adr),
    .wdata      (wdata),
    .rdata      (rdata),
    .irq        (irq),
    .irqid      (irqid),
    .busy       (busy)
  );

  initial begin
    ph1 = 1'b0;
    forever #5 ph1 = ~ph1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Behavioural model: pin sample history, edge-pending bits, handshake state
  // --------------------------------------------------------------------------
  logic [7:0] hist [SYNC+1];   // hist[0] = most recent pin sample
  logic [7:0] m_mask, m_edge, m_pend;
  int         m_state;
  logic [2:0] m_id;

  function automatic logic [2:0] lowest(input logic [7:0] v);
    logic [7:0] iso;
    iso = v & (~v + 8'd1);
    return 3'($clog2(iso));
  endfunction

  function automatic logic [7:0] m_view();
    return (m_pend & m_edge) | (hist[SYNC-1] & ~m_edge);
  endfunction

  task automatic model_edge();
    logic [7:0] req, rise, clr;
    if (reset) begin
      for (int k = 0; k <= SYNC; k++) hist[k] = 8'h00;
      m_mask = 8'h00; m_edge = 8'hFF; m_pend = 8'h00;
      m_state = M_IDLE; m_id = 3'd0;
    end else begin
      req  = m_view() & m_mask;
      rise = hist[SYNC-1] & ~hist[SYNC];
      clr  = (we && adr == 2'd2) ? wdata : 8'h00;
      if (m_state == M_REQ && ack) clr[m_id] = 1'b1;
      m_pend = (rise | (m_pend & ~clr)) & m_edge;
      if (m_state == M_IDLE) begin
        if (req != 8'h00) begin
          m_id = lowest(req);
          m_state = M_REQ;
        end
      end else if (m_state == M_REQ) begin
        if (ack) m_state = M_SERV;
        else if (!req[m_id]) m_state = M_IDLE;
      end else begin
        if (eret) m_state = M_IDLE;
      end
      if (we && adr == 2'd0) m_mask = wdata;
      if (we && adr == 2'd1) m_edge = wdata;
      for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = interrupts;
    end
  endtask

  function automatic logic [7:0] m_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return m_mask;
      2'd1:    return m_edge;
      2'd2:    return m_view();
      default: return {m_state == M_SERV, m_state == M_REQ, 3'b000, m_id};
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge ph1);
    model_edge();
    @(negedge ph1);
    check("model_irq",   8'(irq),   8'(m_state == M_REQ));
    check("model_busy",  8'(busy),  8'(m_state == M_SERV));
    check("model_irqid", 8'(irqid), 8'(m_id));
    check("model_rdata", rdata,     m_rdata(adr));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    we = 1'b1; adr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [7:0] exp);
    adr = a;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic pulse_ack();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic pulse_eret();
    eret = 1'b1; tick(); eret = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Register vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic       we;
    logic [1:0] adr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{1'b0, 2'd0, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 2'd1, 8'h00, 8'hFF};
    vecs[2]  = '{1'b0, 2'd2, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 2'd3, 8'h00, 8'h00};
    vecs[4]  = '{1'b1, 2'd0, 8'h5A, 8'h5A};
    vecs[5]  = '{1'b1, 2'd1, 8'h3C, 8'h3C};
    vecs[6]  = '{1'b1, 2'd3, 8'hFF, 8'h00};
    vecs[7]  = '{1'b1, 2'd2, 8'hFF, 8'h00};
    vecs[8]  = '{1'b0, 2'd0, 8'h00, 8'h5A};
    vecs[9]  = '{1'b1, 2'd0, 8'h00, 8'h00};
    vecs[10] = '{1'b1, 2'd1, 8'hFF, 8'hFF};

    reset = 1'b1; interrupts = 8'h00; ack = 1'b0; eret = 1'b0;
    we = 1'b0; adr = 2'd0; wdata = 8'h00;

    // ---------------- reset and register table ----------------
    do_reset(3);
    check("rst_irq",   8'(irq),   8'd0);
    check("rst_busy",  8'(busy),  8'd0);
    check("rst_irqid", 8'(irqid), 8'd0);
    for (int v = 0; v < 11; v++) begin
      we = vecs[v].we; adr = vecs[v].adr; wdata = vecs[v].wdata;
      tick();
      check($sformatf("reg_vec%0d", v), rdata, vecs[v].exp);
    end
    we = 1'b0;

    // ---------------- basic handshake ----------------
    wr(2'd0, 8'h03);
    interrupts = 8'h02;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 3) check("hs_irq_early", 8'(irq), 8'd0);
      if (k == 4) begin
        check("hs_irq_lat", 8'(irq), 8'd1);
        check("hs_irqid",   8'(irqid), 8'd1);
      end
    end
    interrupts = 8'h00;
    pulse_ack();
    check("hs_ack_irq",  8'(irq),  8'd0);
    check("hs_ack_busy", 8'(busy), 8'd1);
    rd("hs_ack_pend", 2'd2, 8'h00);

    // ---------------- no disturbance during service ----------------
    interrupts = 8'h02;
    tick(); tick();
    interrupts = 8'h00;
    repeat (4) tick();
    check("svc_irq_quiet", 8'(irq), 8'd0);
    rd("svc_pend", 2'd2, 8'h02);
    pulse_eret();
    check("eret_n_irq", 8'(irq), 8'd0);
    tick();
    check("eret_n1_irq",   8'(irq),   8'd1);
    check("eret_n1_irqid", 8'(irqid), 8'd1);
    wr(2'd2, 8'h02);
    check("w1c_req_hold", 8'(irq), 8'd1);
    rd("w1c_req_pend", 2'd2, 8'h00);
    tick();
    check("withdraw_irq", 8'(irq), 8'd0);

    // ---------------- priority / no preemption ----------------
    do_reset(1);
    wr(2'd0, 8'hFF);
    interrupts = 8'h03;
    tick(); tick();
    interrupts = 8'h00;
    tick(); tick();
    check("prio_irq",   8'(irq),   8'd1);
    check("prio_irqid", 8'(irqid), 8'd0);
    pulse_ack(); pulse_eret(); tick();
    check("prio2_irq",   8'(irq),   8'd1);
    check("prio2_irqid", 8'(irqid), 8'd1);
    pulse_ack(); pulse_eret(); tick();
    check("prio_empty", 8'(irq), 8'd0);
    interrupts = 8'h02;
    tick();
    interrupts = 8'h00;
    repeat (3) tick();
    check("np_first_id", 8'(irqid), 8'd1);
    interrupts = 8'h01;
    tick();
    interrupts = 8'h00;
    repeat (5) tick();
    check("np_irq",   8'(irq),   8'd1);
    check("np_irqid", 8'(irqid), 8'd1);
    pulse_ack(); pulse_eret(); tick();
    check("np_after_id", 8'(irqid), 8'd0);
    pulse_ack(); pulse_eret();

    // ---------------- level mode and masking ----------------
    do_reset(1);
    wr(2'd1, 8'hFE);
    wr(2'd0, 8'h01);
    interrupts = 8'h01;
    repeat (3) tick();
    check("lvl_irq", 8'(irq), 8'd1);
    pulse_ack();
    rd("lvl_ack_pend", 2'd2, 8'h01);
    pulse_eret(); tick();
    check("lvl_reassert", 8'(irq), 8'd1);
    interrupts = 8'h00;
    tick(); tick();
    check("lvl_drop_hold", 8'(irq), 8'd1);
    tick();
    check("lvl_drop", 8'(irq), 8'd0);
    interrupts = 8'h04;
    tick();
    interrupts = 8'h00;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("masked_no_irq", 8'(irq), 8'd0);
    end
    rd("masked_pend", 2'd2, 8'h04);

    // ---------------- reset mid-operation ----------------
    do_reset(1);
    wr(2'd1, 8'h7F);
    wr(2'd0, 8'h04);
    interrupts = 8'h04;
    tick();
    interrupts = 8'h00;
    repeat (3) tick();
    check("mid_irqid", 8'(irqid), 8'd2);
    pulse_ack();
    check("mid_busy", 8'(busy), 8'd1);
    do_reset(1);
    check("mid_rst_busy",  8'(busy),  8'd0);
    check("mid_rst_irq",   8'(irq),   8'd0);
    check("mid_rst_irqid", 8'(irqid), 8'd0);
    rd("mid_rst_mask", 2'd0, 8'h00);
    rd("mid_rst_edge", 2'd1, 8'hFF);
    pulse_eret();
    check("mid_eret_busy", 8'(busy), 8'd0);
    check("mid_eret_irq",  8'(irq),  8'd0);

    // ---------------- W1C vs. simultaneous new edge ----------------
    interrupts = 8'h08;
    tick();
    interrupts = 8'h00;
    repeat (4) tick();
    rd("sim_pend_set", 2'd2, 8'h08);
    wr(2'd2, 8'h08);
    rd("sim_w1c_clear", 2'd2, 8'h00);
    interrupts = 8'h08;
    tick();
    interrupts = 8'h00;
    tick();
    we = 1'b1; adr = 2'd2; wdata = 8'h08;
    tick();
    we = 1'b0;
    rd("sim_set_wins", 2'd2, 8'h08);

    // ---------------- randomized traffic vs. model ----------------
    do_reset(2);
    wr(2'd1, 8'($urandom));
    wr(2'd0, 8'($urandom));
    for (int n = 0; n < 2000; n++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(7) == 0) interrupts[b] = ~interrupts[b];
      end
      ack   = ($urandom_range(3) == 0);
      eret  = ($urandom_range(5) == 0);
      we    = ($urandom_range(9) == 0);
      adr   = 2'($urandom_range(3));
      if (we && adr == 2'd1) adr = 2'd0;
      wdata = 8'($urandom);
      reset = ($urandom_range(299) == 0);
      tick();
    end
    reset = 1'b0; ack = 1'b0; eret = 1'b0; we = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
